// File: rtl/odometer_record_gen_if.sv
// odometer_record_gen_if: control inputs and mileage/scan outputs of the odometer record generator
// master drives power_on/drive_state/gear/clr_record and observes clk_bps/record/record_full/moving;
// slave is the generator side.
interface odometer_record_gen_if;
  logic        power_on;
  logic [1:0]  drive_state;
  logic [2:0]  gear;
  logic        clr_record;
  logic        clk_bps;
  logic [26:0] record;
  logic        record_full;
  logic        moving;
  modport master (output power_on, drive_state, gear, clr_record, input clk_bps, record, record_full, moving);
  modport slave (input power_on, drive_state, gear, clr_record, output clk_bps, record, record_full, moving);
endinterface

// File: rtl/odometer_record_gen.sv
// odometer_record_gen: gear-scaled trip mileage accumulator with saturating record and free-running scan strobe
// clk, rst_n (async active-low); bus.slave: power_on, drive_state, gear, clr_record in;
// clk_bps, record, record_full, moving out (all registered).
module odometer_record_gen #(
  parameter int SCAN_DIV   = 100_000,
  parameter int UNIT_DIV   = 10_000_000,
  parameter int MAX_RECORD = 9_999_999
) (
  input logic clk,
  input logic rst_n,
  odometer_record_gen_if.slave bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int UW = $clog2(UNIT_DIV);
  typedef enum logic [1:0] {OFF, IDLE, MOVING} state_t;
  state_t state, next;
  logic [SW-1:0] scan_cnt;
  logic [UW-1:0] unit_cnt;
  logic [2:0] gear_eff;
  logic go, tick, sat;
  logic [27:0] sum;
  always_comb begin
    gear_eff = bus.gear > 3'd5 ? 3'd0 : bus.gear;
    go = (bus.drive_state == 2'b01 || bus.drive_state == 2'b10) && gear_eff != 3'd0;
    next = state == OFF ? (bus.power_on ? IDLE : OFF) : !bus.power_on ? OFF : go ? MOVING : IDLE;
    tick = state == MOVING && unit_cnt == UW'(UNIT_DIV - 1);
    // one spare bit so a record near 2^27 plus a gear cannot wrap before the ceiling test
    sum = {1'b0, bus.record} + 28'(gear_eff);
    sat = sum >= 28'(MAX_RECORD);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      bus.clk_bps <= 1'b0;
    end else begin
      scan_cnt <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + SW'(1);
      bus.clk_bps <= scan_cnt == SW'(SCAN_DIV - 1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      bus.moving <= 1'b0;
      unit_cnt <= '0;
      bus.record <= '0;
      bus.record_full <= 1'b0;
    end else begin
      state <= next;
      bus.moving <= next == MOVING;
      // partial counts are dropped whenever MOVING is left or not yet entered
      unit_cnt <= (state == MOVING && next == MOVING && !tick) ? unit_cnt + UW'(1) : '0;
      if (bus.clr_record || (state == OFF && next == IDLE)) begin
        bus.record <= '0;
        bus.record_full <= 1'b0;
      end else if (tick) begin
        bus.record <= sat ? 27'(MAX_RECORD) : sum[26:0];
        bus.record_full <= bus.record_full | sat;
      end
    end
  end
endmodule

// File: tb/tb_odometer_record_gen.sv
// tb_odometer_record_gen: directed checks of scan strobe, trip accumulation, saturation, clears and async reset
module tb_odometer_record_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  odometer_record_gen_if bus ();
  odometer_record_gen #(.SCAN_DIV(4), .UNIT_DIV(10), .MAX_RECORD(50)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask
  initial begin
    bus.power_on = 1'b0;
    bus.drive_state = 2'b00;
    bus.gear = 3'd0;
    bus.clr_record = 1'b0;
    step(2);
    chk("rst_bps", bus.clk_bps, 0);
    chk("rst_record", bus.record, 0);
    chk("rst_full", bus.record_full, 0);
    chk("rst_moving", bus.moving, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("scan_bps", bus.clk_bps, (i % 4 == 0) ? 1 : 0);
    end
    chk("scan_record", bus.record, 0);
    chk("scan_moving", bus.moving, 0);
    bus.power_on = 1'b1;
    bus.drive_state = 2'b01;
    bus.gear = 3'd3;
    step(1);
    chk("fwd_idle", bus.moving, 0);
    step(1);
    chk("fwd_moving", bus.moving, 1);
    step(9);
    chk("fwd_pre_tick", bus.record, 0);
    step(1);
    chk("fwd_rec3", bus.record, 3);
    step(10);
    chk("fwd_rec6", bus.record, 6);
    step(10);
    chk("fwd_rec9", bus.record, 9);
    step(3);
    bus.drive_state = 2'b00;
    step(1);
    chk("stop_moving", bus.moving, 0);
    step(10);
    chk("stop_hold", bus.record, 9);
    bus.clr_record = 1'b1;
    bus.gear = 3'd5;
    bus.drive_state = 2'b10;
    step(1);
    bus.clr_record = 1'b0;
    chk("clr_idle", bus.record, 0);
    chk("rev_moving", bus.moving, 1);
    for (int k = 1; k <= 11; k++) begin
      step(10);
      chk("sat_record", bus.record, (k * 5 >= 50) ? 50 : k * 5);
      chk("sat_full", bus.record_full, (k * 5 >= 50) ? 1 : 0);
    end
    bus.power_on = 1'b0;
    step(1);
    chk("off_moving", bus.moving, 0);
    chk("off_hold_full", bus.record_full, 1);
    step(3);
    chk("off_hold_rec", bus.record, 50);
    bus.power_on = 1'b1;
    step(1);
    chk("on_clear_rec", bus.record, 0);
    chk("on_clear_full", bus.record_full, 0);
    step(41);
    chk("trip_rec20", bus.record, 20);
    bus.power_on = 1'b0;
    step(1);
    chk("off2_moving", bus.moving, 0);
    step(5);
    chk("off2_hold", bus.record, 20);
    bus.power_on = 1'b1;
    bus.gear = 3'd2;
    step(1);
    chk("on2_clear", bus.record, 0);
    chk("on2_full", bus.record_full, 0);
    step(61);
    chk("pre_clr_rec12", bus.record, 12);
    step(9);
    bus.clr_record = 1'b1;
    step(1);
    bus.clr_record = 1'b0;
    chk("clr_beats_tick", bus.record, 0);
    step(9);
    chk("clr_no_late", bus.record, 0);
    step(1);
    chk("clr_next_tick", bus.record, 2);
    bus.gear = 3'd5;
    step(30);
    chk("pre_rst_rec17", bus.record, 17);
    step(4);
    rst_n = 1'b0;
    #1;
    chk("async_record", bus.record, 0);
    chk("async_moving", bus.moving, 0);
    chk("async_full", bus.record_full, 0);
    chk("async_bps", bus.clk_bps, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rel_idle", bus.moving, 0);
    step(1);
    chk("rel_moving", bus.moving, 1);
    step(1);
    chk("rel_bps3", bus.clk_bps, 0);
    step(1);
    chk("rel_bps4", bus.clk_bps, 1);
    step(7);
    chk("rel_pre_tick", bus.record, 0);
    step(1);
    chk("rel_rec5", bus.record, 5);
    bus.gear = 3'd6;
    step(1);
    chk("gear6_idle", bus.moving, 0);
    bus.gear = 3'd3;
    bus.drive_state = 2'b11;
    step(2);
    chk("drive11_idle", bus.moving, 0);
    chk("drive11_hold", bus.record, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/odometer_record_gen.md
Name: odometer_record_gen

Overview:
- Upstream feeder of the seven-segment scan/flash stage: produces the 27-bit binary mileage value `record` and the one-cycle scan strobe `clk_bps` that the display stage consumes.
- Accumulates distance while the vehicle is powered and moving, scaled by the selected manual gear.
- Saturates at the 7-digit display limit and flags saturation.

Parameters:
- SCAN_DIV, 100_000, clk cycles between `clk_bps` pulses (1 kHz at 100 MHz); legal range ≥2.
- UNIT_DIV, 10_000_000, clk cycles of continuous MOVING per distance unit tick; legal range ≥2.
- MAX_RECORD, 9_999_999, saturation ceiling for `record`; must be < 2^27.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- power_on  input  1  level: vehicle powered, active-high.
- drive_state  input  2  00 stop, 01 forward, 10 reverse, 11 reserved (treated as stop).
- gear  input  3  manual gear 0 (neutral) to 5; values 6 and 7 are treated as 0.
- clr_record  input  1  synchronous one-cycle clear request.
- clk_bps  output  1  one-cycle scan strobe, free-running.
- record  output  27  accumulated mileage, binary.
- record_full  output  1  sticky: record has reached MAX_RECORD.
- moving  output  1  high while in state MOVING.

Behaviour:
- Reset (rst_n low, asynchronous): `clk_bps`=0, `record`=0, `record_full`=0, `moving`=0, state=OFF, both prescalers=0.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 every cycle, independent of power.
  - `clk_bps` is 1 for exactly the cycle after the count wraps from SCAN_DIV-1 to 0.
  - First pulse occurs SCAN_DIV cycles after reset release; period is exactly SCAN_DIV.
- State machine (registered; transitions take effect at the next clk edge):
  - OFF: enter IDLE when power_on=1. On that transition, `record` clears to 0 and `record_full` clears to 0 (new trip).
  - IDLE: go to OFF if power_on=0. Otherwise go to MOVING if drive_state is 01 or 10 and the effective gear is nonzero.
  - MOVING: go to OFF if power_on=0 (takes priority). Otherwise go to IDLE if drive_state is 00/11 or the effective gear becomes 0.
  - `moving` = (state==MOVING), registered together with the state.
- Unit prescaler:
  - Counts only in MOVING; forced to 0 in any other state.
  - On reaching UNIT_DIV-1 it wraps to 0 and issues an internal unit tick. The first tick falls UNIT_DIV cycles after entering MOVING.
  - Leaving MOVING mid-count discards the partial count; no tick is issued.
- Accumulation on a unit tick:
  - Compute record + gear (gear zero-extended to 27 bits).
  - If the sum ≥ MAX_RECORD, set `record`=MAX_RECORD and `record_full`=1. Otherwise `record` takes the sum.
  - Forward and reverse both add; distance is unsigned.
  - With `record_full`=1, further ticks leave `record` unchanged.
- Hold rules:
  - In OFF and IDLE, `record` holds its value. Power-off does not clear it; only the next power-on clears it.
- clr_record:
  - Sets `record`=0 and `record_full`=0 next cycle in any state.
  - Has priority over a coincident unit tick; that tick's increment is lost.
  - The unit prescaler is not reset by clr_record.
- Gear change during MOVING between 1 and 5 does not reset the prescaler. The new gear is used at the next tick.
- All outputs are registered; `record` changes exactly one cycle after the tick cycle.

Test Plan:
(SCAN_DIV=4, UNIT_DIV=10, MAX_RECORD=50 unless noted)
- Reset release, no other stimulus -> `clk_bps` pulses at cycles 4, 8, 12 (1 cycle wide); `record`=0, `moving`=0 throughout.
- power_on=1, drive_state=01, gear=3 for 35 cycles, then drive_state=00 -> `moving` high from cycle 2; `record` steps 3, 6, 9 at 10-cycle intervals; after stop, `record` holds 9.
- gear=5, drive_state=10, moving until saturation -> `record` sequence 5, 10, …, 45, then 50 with `record_full`=1; next tick leaves `record`=50.
- `record`=20, power_on 1→0→1 -> `record` holds 20 while OFF; 0 and `record_full`=0 one cycle after power returns.
- clr_record asserted in the same cycle as a unit tick with `record`=12, gear=2 -> `record`=0 next cycle (not 2); the following tick 10 cycles later gives 2.
- rst_n low mid-MOVING at `record`=17, prescaler mid-count -> all outputs 0 immediately (asynchronous); after release with power_on=1, the first increment comes UNIT_DIV cycles after MOVING is re-entered.
